multiword_add_seq: RTL
======================

MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 Parameter NWORDS, default 4: number of 16-bit words per operand; operand width W = 16*NWORDS; legal range 2..8.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand set a/b/cin is valid.
REQ-005 in_ready  output  1  block accepts a new operand set.
REQ-006 a  input  W  first operand.
REQ-007 b  input  W  second operand.
REQ-008 cin  input  1  carry into word 0.
REQ-009 add_x  output  16  operand word X driven to the external 16-bit adder.
REQ-010 add_y  output  16  operand word Y driven to the external 16-bit adder.
REQ-011 add_ci  output  1  carry-in driven to the external 16-bit adder.
REQ-012 add_z  input  16  sum word returned by the external adder; combinational in add_x/add_y/add_ci, same cycle.
REQ-013 add_co  input  1  carry-out returned by the external adder, same cycle.
REQ-014 out_valid  output  1  sum/cout hold a completed result.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 sum  output  W  registered W-bit sum.
REQ-017 cout  output  1  registered final carry-out.

Function
REQ-018 FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-019 IDLE: on in_valid & in_ready, register a, b, cin; clear word index to 0; go to RUN. in_valid alone in RUN/DONE is ignored, with no capture.
REQ-020 RUN, index i: add_x = a_reg[16i+15:16i], add_y = b_reg[16i+15:16i], add_ci = cin_reg when i = 0, else carry_reg.
REQ-021 RUN, each edge: sum[16i+15:16i] <= add_z; carry_reg <= add_co; i <= i+1.
REQ-022 At i = NWORDS-1, the edge also loads cout <= add_co and moves to DONE.
REQ-023 Latency: capture edge E; out_valid high after edge E+NWORDS; exactly NWORDS RUN cycles.
REQ-024 Outside RUN, add_x, add_y and add_ci SHALL be 0.
REQ-025 DONE: sum and cout held stable while out_ready = 0; on out_ready = 1, return to IDLE on that edge.
REQ-026 No same-cycle turnaround: a new operand set is accepted no earlier than the cycle after the DONE->IDLE edge.
REQ-027 sum and cout retain their last result in IDLE until the next RUN overwrites word 0.
REQ-028 Addition is unsigned modulo 2^W; the carry out of word NWORDS-1 appears only on cout.

Reset
REQ-029 rst_n low, at any time, forces IDLE asynchronously: sum = 0, cout = 0, out_valid = 0, add_x/add_y/add_ci = 0, internal registers cleared, in_ready = 0 while rst_n is low.
REQ-030 in_ready = 1 from the first cycle after rst_n deasserts.
REQ-031 Reset during RUN or DONE discards the operation; no out_valid pulse follows.

Configuration
REQ-032 Macro MULTIWORD_ADD_OVF_EN defined: extra output ovf (1 bit), registered with cout, = carry into MSB XOR carry out of MSB (two's-complement overflow), reset 0.
REQ-033 Macro MULTIWORD_ADD_OVF_EN undefined: no ovf port and no overflow logic; all other behaviour identical.

Verification (NWORDS = 4, external port driven by a correct 16-bit adder model)
REQ-034 a = 3752, b = 21007, cin = 0 -> sum = 24759, cout = 0, out_valid exactly 4 cycles after capture.
REQ-035 a = 0x0000_0000_0000_FFFF, b = 1, cin = 0 -> sum = 0x0000_0000_0001_0000; add_ci = 1 in RUN cycle 1 (inter-word carry).
REQ-036 a = 0xFFFF_FFFF_FFFF_FFFF, b = 0, cin = 1 -> sum = 0, cout = 1; ovf = 0 when the macro is enabled.
REQ-037 a = 0x7FFF_FFFF_FFFF_FFFF, b = 1 -> sum = 0x8000_0000_0000_0000, cout = 0, ovf = 1 (macro enabled).
REQ-038 out_ready held 0 for 3 cycles in DONE -> sum/cout stable, in_ready = 0, in_valid ignored; out_ready = 1 -> IDLE next cycle.
REQ-039 rst_n pulsed low in RUN cycle 2 -> all outputs 0 immediately, no out_valid; next transaction a = 1, b = 2 -> sum = 3.

Source files
------------

// File: rtl/multiword_add_seq.sv
// Sequential W-bit adder that reuses one external 16-bit adder, one word per cycle, LSW first.
// Optional two's-complement overflow output `ovf` is enabled by defining MULTIWORD_ADD_OVF_EN.
module multiword_add_seq #(
  parameter int NWORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [16*NWORDS-1:0]   a,
  input  logic [16*NWORDS-1:0]   b,
  input  logic                   cin,
  output logic [15:0]            add_x,
  output logic [15:0]            add_y,
  output logic                   add_ci,
  input  logic [15:0]            add_z,
  input  logic                   add_co,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [16*NWORDS-1:0]   sum,
`ifdef MULTIWORD_ADD_OVF_EN
  output logic                   ovf,
`endif
  output logic                   cout
);
  localparam int IW = $clog2(NWORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]              state;
  logic [NWORDS-1:0][15:0] a_reg, b_reg, sum_reg;
  logic                    cin_reg, carry_reg;
  logic [IW-1:0]           idx;
  logic                    last;

  assign last      = (idx == IW'(NWORDS-1));
  assign in_ready  = rst_n && (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign sum       = sum_reg;

  // The external adder sees zeros whenever no word is in flight.
  always_comb begin
    add_x  = '0;
    add_y  = '0;
    add_ci = 1'b0;
    if (state == S_RUN) begin
      add_x  = a_reg[idx];
      add_y  = b_reg[idx];
      add_ci = (idx == '0) ? cin_reg : carry_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cin_reg   <= 1'b0;
      carry_reg <= 1'b0;
      idx       <= '0;
      cout      <= 1'b0;
`ifdef MULTIWORD_ADD_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_reg   <= a;
            b_reg   <= b;
            cin_reg <= cin;
            idx     <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          sum_reg[idx] <= add_z;
          carry_reg    <= add_co;
          idx          <= idx + 1'b1;
          if (last) begin
            cout  <= add_co;
`ifdef MULTIWORD_ADD_OVF_EN
            // Carry into the MSB is recovered from the MSB sum bit and its operands.
            ovf   <= add_co ^ (add_z[15] ^ add_x[15] ^ add_y[15]);
`endif
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
